shade_scheduler: RTL and testbench
==================================

Name: shade_scheduler

Overview:
- Sequences per-pixel shading requests from N_REQ ray-march cores through one shared combinational shading unit (Q8.24 normal/light in, packed RGB888 out).
- Round-robin arbitrates between requesters and snapshots normal, light direction and tag into operand registers.
- Captures the shading result one cycle later and presents it on a valid/ready output to the framebuffer writer.
- Holds the programmable light direction and a completed-hit counter.

Parameters:
- DATA_WIDTH, 32, fixed-point operand width (Q8.24).
- OUT_WIDTH, 24, packed RGB888 width.
- N_REQ, 2, number of requesters (2..8).
- TAG_WIDTH, 20, pixel address/tag width.
- BG_COLOR, 24'h000000, colour returned for miss pixels.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_hit  in  N_REQ  1 = ray hit surface, 0 = miss.
- req_nx, req_ny, req_nz  in  N_REQ*DATA_WIDTH each  flattened normals; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_tag  in  N_REQ*TAG_WIDTH  flattened pixel tags.
- cfg_we  in  1  light-direction write strobe.
- cfg_lx, cfg_ly, cfg_lz  in  DATA_WIDTH each  new light direction (Q8.24).
- sh_nx, sh_ny, sh_nz, sh_lx, sh_ly, sh_lz  out  DATA_WIDTH each  operands to shading unit.
- sh_shade  in  OUT_WIDTH  shading unit result (combinational from sh_*).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_pixel  out  OUT_WIDTH  RGB888 result.
- out_tag  out  TAG_WIDTH  tag of result.
- out_src  out  clog2(N_REQ)  index of originating requester.
- hit_count  out  16  completed hit pixels; wraps 0xFFFF -> 0.

Behaviour:
- States: IDLE, SHADE, HOLD.
  - IDLE: any req_valid -> grant, SHADE.
  - SHADE: always -> HOLD.
  - HOLD with out_ready=1: -> SHADE if a request is granted in the same cycle, else IDLE.
  - HOLD with out_ready=0: stay in HOLD.
- req_ready: asserted only for the granted index, only in IDLE or in (HOLD and out_ready). Zero in SHADE.
- Arbitration is round-robin.
  - Search starts at (last_grant+1) mod N_REQ; lowest index found from there wins.
  - last_grant resets to N_REQ-1, so requester 0 wins first.
  - last_grant updates only on an accept.
- Accept cycle T (valid&ready):
  - Latch sh_nx/ny/nz, hit flag, tag and source index.
  - Copy the current light registers into sh_lx/ly/lz.
  - If cfg_we is also asserted in cycle T, the request uses the old light value.
- Cycle T+1 (SHADE): register out_pixel = hit ? sh_shade : BG_COLOR, plus out_tag and out_src.
- Cycle T+2: out_valid=1. Accept-to-valid latency is 2 cycles.
- HOLD backpressure: out_valid, out_pixel, out_tag and out_src stay stable until out_ready.
- Peak throughput is one result per 2 cycles when out_ready is held high.
- hit_count increments on an output handshake (out_valid&out_ready) whose hit flag is 1.
- Light registers:
  - Written on cfg_we in any state.
  - Used only for requests accepted after the write cycle.
  - In-flight requests are unaffected.
- Reset (any state, including mid-transaction):
  - state IDLE, out_valid 0, req_ready 0 during the reset cycle.
  - out_pixel 0, out_tag 0, out_src 0, hit_count 0.
  - sh_* operands 0, except sh_ly = 32'h01000000.
  - Light registers (0, 1.0, 0) = 0, 32'h01000000, 0.
  - The in-flight request is dropped and no output is produced for it.
- Requests are never dropped once accepted. A requester may drop req_valid before acceptance without effect.

Test Plan:
- Reset, then requester 0 hit, n=(0,1.0,0), tag 5 -> out_valid at T+2, out_pixel = sh_shade (model: 0xCCB37F for light (0,1,0)), out_tag 5, out_src 0, hit_count 1 after handshake.
- Both requesters valid continuously, out_ready=1 -> grant order 0,1,0,1; one result every 2 cycles; out_src alternates.
- out_ready low for 5 cycles while in HOLD -> outputs stable, req_ready all 0, no new accept; release -> handshake, then the next grant in the same cycle.
- Miss request (req_hit=0), tag 9 -> out_pixel = BG_COLOR regardless of sh_shade, hit_count unchanged.
- cfg_we with light (1.0,0,0) in the accept cycle -> that request sees old light on sh_l*; the next request sees the new light.
- rst asserted in SHADE -> next cycle out_valid 0, hit_count 0, state IDLE; the pending tag never appears on out_tag with out_valid.

Source files
------------

// File: rtl/shade_scheduler.sv
// shade_scheduler
//   Arbitrates per-pixel shading requests from N_REQ ray-march cores onto one
//   shared combinational shading unit and returns RGB888 results on a
//   valid/ready port.
//
//   state | meaning
//   IDLE  | no work in flight, may accept a request
//   SHADE | operands latched, capture the shading result this cycle
//   HOLD  | result presented, waiting for out_ready (may accept on release)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/ready/hit/tag    per-requester handshake, hit flag, pixel tag
//   req_nx/ny/nz               flattened per-requester surface normals (Q8.24)
//   cfg_we, cfg_lx/ly/lz       light-direction write port
//   sh_nx..sh_lz, sh_shade     operands to / result from the shading unit
//   out_valid/ready/pixel/tag/src  result port to the framebuffer writer
//   hit_count                  number of completed hit pixels (wrapping)
module shade_scheduler #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  OUT_WIDTH  = 24,
  parameter int                  N_REQ      = 2,
  parameter int                  TAG_WIDTH  = 20,
  parameter logic [OUT_WIDTH-1:0] BG_COLOR  = 24'h000000,
  localparam int                 SRC_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_hit,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_nx,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_ny,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_nz,
  input  logic [N_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic                        cfg_we,
  input  logic [DATA_WIDTH-1:0]       cfg_lx,
  input  logic [DATA_WIDTH-1:0]       cfg_ly,
  input  logic [DATA_WIDTH-1:0]       cfg_lz,
  output logic [DATA_WIDTH-1:0]       sh_nx,
  output logic [DATA_WIDTH-1:0]       sh_ny,
  output logic [DATA_WIDTH-1:0]       sh_nz,
  output logic [DATA_WIDTH-1:0]       sh_lx,
  output logic [DATA_WIDTH-1:0]       sh_ly,
  output logic [DATA_WIDTH-1:0]       sh_lz,
  input  logic [OUT_WIDTH-1:0]        sh_shade,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_pixel,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic [SRC_W-1:0]            out_src,
  output logic [15:0]                 hit_count
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << 24;

  typedef enum logic [1:0] {IDLE, SHADE, HOLD} state_t;

  state_t                state;
  logic [SRC_W-1:0]      last_grant;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_found;
  logic                  can_accept;
  logic                  accept;
  int                    rr_idx;
  logic                  hit_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SRC_W-1:0]      src_q;
  logic                  out_hit;
  logic [DATA_WIDTH-1:0] light_x, light_y, light_z;

  // Round-robin: scan starting one past the last accepted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    rr_idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = (int'(last_grant) + k) % N_REQ;
      if (!grant_found && req_valid[rr_idx[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx[SRC_W-1:0];
      end
    end
  end

  // A new request can enter while the previous result leaves on out_ready.
  assign can_accept = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept     = can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(N_REQ - 1);
      sh_nx      <= '0;
      sh_ny      <= '0;
      sh_nz      <= '0;
      sh_lx      <= '0;
      sh_ly      <= ONE;
      sh_lz      <= '0;
      light_x    <= '0;
      light_y    <= ONE;
      light_z    <= '0;
      hit_q      <= 1'b0;
      tag_q      <= '0;
      src_q      <= '0;
      out_hit    <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_tag    <= '0;
      out_src    <= '0;
      hit_count  <= '0;
    end else begin
      if (cfg_we) begin
        light_x <= cfg_lx;
        light_y <= cfg_ly;
        light_z <= cfg_lz;
      end

      // Operands take the light value from before any same-cycle write.
      if (accept) begin
        sh_nx      <= req_nx[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sh_ny      <= req_ny[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sh_nz      <= req_nz[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sh_lx      <= light_x;
        sh_ly      <= light_y;
        sh_lz      <= light_z;
        hit_q      <= req_hit[grant_idx];
        tag_q      <= req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
        src_q      <= grant_idx;
        last_grant <= grant_idx;
      end

      // out_hit is kept apart from hit_q, which a same-cycle accept overwrites.
      if (out_valid && out_ready && out_hit) hit_count <= hit_count + 16'd1;

      case (state)
        IDLE: begin
          if (accept) state <= SHADE;
        end
        SHADE: begin
          out_pixel <= hit_q ? sh_shade : BG_COLOR;
          out_tag   <= tag_q;
          out_src   <= src_q;
          out_hit   <= hit_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? SHADE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shade_scheduler.sv
// tb_shade_scheduler
//   Drives directed and randomized traffic into shade_scheduler and compares
//   every cycle against a transaction-level reference model. The shading unit
//   is modelled as base colour 0xCCB37F scaled by clamp(dot(n,l), 0, 1).
module tb_shade_scheduler;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int TW  = 20;
  localparam logic [23:0] BG  = 24'h000000;
  localparam logic [31:0] ONE = 32'h01000000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_hit;
  logic [N*DW-1:0] req_nx, req_ny, req_nz;
  logic [N*TW-1:0] req_tag;
  logic            cfg_we;
  logic [DW-1:0]   cfg_lx, cfg_ly, cfg_lz;
  logic [DW-1:0]   sh_nx, sh_ny, sh_nz, sh_lx, sh_ly, sh_lz;
  logic [23:0]     sh_shade;
  logic            out_valid, out_ready;
  logic [23:0]     out_pixel;
  logic [TW-1:0]   out_tag;
  logic [0:0]      out_src;
  logic [15:0]     hit_count;

  int checks = 0;
  int errors = 0;

  shade_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
    .req_nx(req_nx), .req_ny(req_ny), .req_nz(req_nz), .req_tag(req_tag),
    .cfg_we(cfg_we), .cfg_lx(cfg_lx), .cfg_ly(cfg_ly), .cfg_lz(cfg_lz),
    .sh_nx(sh_nx), .sh_ny(sh_ny), .sh_nz(sh_nz),
    .sh_lx(sh_lx), .sh_ly(sh_ly), .sh_lz(sh_lz), .sh_shade(sh_shade),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_tag(out_tag), .out_src(out_src), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] shade_fn(input logic [31:0] nx, ny, nz, lx, ly, lz);
    longint d, r, g, b;
    d = (longint'($signed(nx)) * longint'($signed(lx)) +
         longint'($signed(ny)) * longint'($signed(ly)) +
         longint'($signed(nz)) * longint'($signed(lz))) >>> 24;
    if (d < 0) d = 0;
    if (d > 64'sd16777216) d = 64'sd16777216;
    r = (longint'(204) * d) >>> 24;
    g = (longint'(179) * d) >>> 24;
    b = (longint'(127) * d) >>> 24;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  assign sh_shade = shade_fn(sh_nx, sh_ny, sh_nz, sh_lx, sh_ly, sh_lz);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one request in flight; age counts cycles since
  // acceptance (1 = being shaded, 2 = result on the output port).
  bit          have = 0;
  int          age = 0;
  int          it_src;
  logic [19:0] it_tag;
  bit          it_hit;
  logic [23:0] it_pix;
  logic [31:0] m_n [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] m_l [3] = '{32'h0, ONE, 32'h0};
  logic [31:0] light [3] = '{32'h0, ONE, 32'h0};
  int          last_g = N - 1;
  logic [15:0] hcnt = 16'h0;

  task automatic tick();
    bit exp_v, can, found;
    int g, idx;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    exp_v = have && (age >= 2);
    check_val("out_valid", 64'(out_valid), 64'(exp_v));
    check_val("hit_count", 64'(hit_count), 64'(hcnt));
    if (exp_v) begin
      check_val("out_pixel", 64'(out_pixel), 64'(it_pix));
      check_val("out_tag", 64'(out_tag), 64'(it_tag));
      check_val("out_src", 64'(out_src), 64'(it_src));
    end
    check_val("sh_nx", 64'(sh_nx), 64'(m_n[0]));
    check_val("sh_ny", 64'(sh_ny), 64'(m_n[1]));
    check_val("sh_nz", 64'(sh_nz), 64'(m_n[2]));
    check_val("sh_lx", 64'(sh_lx), 64'(m_l[0]));
    check_val("sh_ly", 64'(sh_ly), 64'(m_l[1]));
    check_val("sh_lz", 64'(sh_lz), 64'(m_l[2]));

    can   = !rst && (!have || (age >= 2 && out_ready));
    found = 0;
    g     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (last_g + k) % N;
      if (!found && req_valid[idx]) begin found = 1; g = idx; end
    end
    exp_rdy = '0;
    if (can && found) exp_rdy[g] = 1'b1;
    check_val("req_ready", 64'(req_ready), 64'(exp_rdy));

    if (rst) begin
      have = 0; hcnt = 0; last_g = N - 1;
      light = '{32'h0, ONE, 32'h0};
      m_n   = '{32'h0, 32'h0, 32'h0};
      m_l   = '{32'h0, ONE, 32'h0};
    end else begin
      if (exp_v && out_ready) begin
        if (it_hit) hcnt = hcnt + 16'd1;
        have = 0;
      end else if (have && age < 2) begin
        age++;
      end
      if (can && found) begin
        have   = 1;
        age    = 1;
        it_src = g;
        it_tag = req_tag[g*TW +: TW];
        it_hit = req_hit[g];
        m_n    = '{req_nx[g*DW +: DW], req_ny[g*DW +: DW], req_nz[g*DW +: DW]};
        m_l    = light;
        it_pix = it_hit ? shade_fn(m_n[0], m_n[1], m_n[2], m_l[0], m_l[1], m_l[2]) : BG;
        last_g = g;
      end
      if (cfg_we) light = '{cfg_lx, cfg_ly, cfg_lz};
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_q();
    return 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
  endfunction

  task automatic drive_rand(input int p_valid, input int p_ready, input int p_cfg, input int p_rst);
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = ($urandom_range(0, 99) < p_valid);
      req_hit[i]           = ($urandom_range(0, 3) != 0);
      req_nx[i*DW +: DW]   = rnd_q();
      req_ny[i*DW +: DW]   = ($urandom_range(0, 1) == 1) ? ONE : rnd_q();
      req_nz[i*DW +: DW]   = rnd_q();
      req_tag[i*TW +: TW]  = TW'($urandom);
    end
    out_ready = ($urandom_range(0, 99) < p_ready);
    cfg_we    = ($urandom_range(0, 99) < p_cfg);
    cfg_lx    = rnd_q();
    cfg_ly    = rnd_q();
    cfg_lz    = rnd_q();
    rst       = ($urandom_range(0, 999) < p_rst);
  endtask

  task automatic set_req(input int i, input bit hit, input logic [31:0] nx, ny, nz,
                         input logic [19:0] tag);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    req_hit[i]   = hit;
    req_nx[i*DW +: DW]  = nx;
    req_ny[i*DW +: DW]  = ny;
    req_nz[i*DW +: DW]  = nz;
    req_tag[i*TW +: TW] = tag;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_hit = '0; req_nx = '0; req_ny = '0; req_nz = '0;
    req_tag = '0; cfg_we = 1'b0; cfg_lx = '0; cfg_ly = '0; cfg_lz = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_sh_ly", 64'(sh_ly), 64'(ONE));
    check_val("rst_pixel", 64'(out_pixel), 64'h0);

    // First hit from requester 0 with n = (0,1,0) under default light.
    set_req(0, 1'b1, 32'h0, ONE, 32'h0, 20'd5);
    tick();
    req_valid = '0;
    tick();
    check_val("t1_valid", 64'(out_valid), 64'h1);
    check_val("t1_pixel", 64'(out_pixel), 64'hCCB37F);
    check_val("t1_tag", 64'(out_tag), 64'd5);
    out_ready = 1'b1;
    tick();
    check_val("t1_hits", 64'(hit_count), 64'h1);

    // Light write in the accept cycle: that request keeps the old light.
    set_req(0, 1'b1, ONE, 32'h0, 32'h0, 20'd7);
    cfg_we = 1'b1; cfg_lx = ONE; cfg_ly = 32'h0; cfg_lz = 32'h0;
    tick();
    cfg_we = 1'b0; req_valid = '0;
    tick();
    check_val("cfg_old_ly", 64'(sh_ly), 64'(ONE));
    set_req(1, 1'b0, ONE, 32'h0, 32'h0, 20'd9);
    tick();
    req_valid = '0;
    check_val("cfg_new_lx", 64'(sh_lx), 64'(ONE));
    tick();
    check_val("miss_pixel", 64'(out_pixel), 64'(BG));
    tick();
    tick();

    // Reset while a request is being shaded drops it.
    set_req(1, 1'b1, 32'h0, ONE, 32'h0, 20'h77);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_mid_valid", 64'(out_valid), 64'h0);
    check_val("rst_mid_hits", 64'(hit_count), 64'h0);
    for (int i = 0; i < 4; i++) tick();

    // Randomized phases: saturated, backpressured, sparse, mixed with resets.
    for (int c = 0; c < 400; c++) begin drive_rand(100, 100, 5, 0); tick(); end
    for (int c = 0; c < 400; c++) begin drive_rand(90, 30, 10, 0); tick(); end
    for (int c = 0; c < 400; c++) begin drive_rand(20, 70, 20, 0); tick(); end
    for (int c = 0; c < 800; c++) begin drive_rand(60, 60, 10, 8); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
